// File: rtl/sdram_arbiter_pkg.sv
// rtl/sdram_arbiter_pkg.sv - shared SDRAM command/state encodings and port-index helper
package sdram_arbiter_pkg;

    localparam logic [1:0] CMD_NOP   = 2'd0;
    localparam logic [1:0] CMD_READ  = 2'd1;
    localparam logic [1:0] CMD_WRITE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_OWNED      = 2'd1,
        ST_READ_WAIT  = 2'd2,
        ST_WRITE_WAIT = 2'd3
    } arb_state_e;

    function automatic int port_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sdram_arbiter_rr_select.sv
// rtl/sdram_arbiter_rr_select.sv - combinational round-robin winner pick
module rr_select
    import sdram_arbiter_pkg::*;
#(
    parameter int N_PORTS = 3,
    parameter int PW      = port_idx_w(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [N_PORTS-1:0] winner
);

    // scan ports starting at ptr, wrapping, and take the first requester
    always_comb begin
        int  idx;
        logic found;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < N_PORTS; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N_PORTS) idx = idx - N_PORTS;
            for (int j = 0; j < N_PORTS; j++) begin
                if (!found && (j == idx) && req[j]) begin
                    winner[j] = 1'b1;
                    found     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - multi-port SDRAM arbiter with urgent port and hold limit
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int N_PORTS           = 3,
    parameter int ADDR_WIDTH        = 22,
    parameter int DATA_WIDTH        = 32,
    parameter int READ_BURST_LENGTH = 8,
    parameter int URGENT_PORT       = 1,
    parameter int MAX_HOLD          = 16
) (
    input  logic                          i_Clk,
    input  logic                          i_Reset,
    input  logic [N_PORTS-1:0]            i_Req,
    input  logic [2*N_PORTS-1:0]          i_Command,
    input  logic [ADDR_WIDTH*N_PORTS-1:0] i_Data_Address,
    input  logic [DATA_WIDTH*N_PORTS-1:0] i_Data_Write,
    output logic [N_PORTS-1:0]            o_Grant,
    output logic [1:0]                    o_Command,
    output logic [ADDR_WIDTH-1:0]         o_Data_Address,
    output logic [DATA_WIDTH-1:0]         o_Data_Write,
    input  logic                          i_Data_Read_Valid,
    input  logic                          i_Data_Write_Done,
    output logic [N_PORTS-1:0]            o_Data_Read_Valid,
    output logic [N_PORTS-1:0]            o_Data_Write_Done,
    output logic                          o_Busy
);

    localparam int PW = port_idx_w(N_PORTS);
    localparam int BW = $clog2(READ_BURST_LENGTH + 1);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [BW-1:0]      LAST_BEAT = BW'(READ_BURST_LENGTH - 1);
    localparam logic [HW-1:0]      HOLD_MAX  = HW'(MAX_HOLD);
    localparam logic [PW-1:0]      LAST_PORT = PW'(N_PORTS - 1);
    localparam logic [PW-1:0]      URG_IDX   = PW'(URGENT_PORT);
    localparam logic [N_PORTS-1:0] URG_OH    = N_PORTS'(1) << URGENT_PORT;

    arb_state_e              state, state_n;
    logic [N_PORTS-1:0]      grant, grant_n;
    logic [PW-1:0]           owner, owner_n, ptr, ptr_n;
    logic [HW-1:0]           hold, hold_n, hold_inc;
    logic [BW-1:0]           beat, beat_n;
    logic [1:0]              cmd_reg, cmd_n;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_n;
    logic [DATA_WIDTH-1:0]   data_reg, data_n;

    logic [N_PORTS-1:0]      rr_oh, pick_oh;
    logic [PW-1:0]           pick_idx;
    logic                    owner_req;
    logic [1:0]              owner_cmd;
    logic [ADDR_WIDTH-1:0]   owner_addr;
    logic [DATA_WIDTH-1:0]   owner_data;
    logic                    busy, done, stay;

    rr_select #(.N_PORTS(N_PORTS), .PW(PW)) u_rr_select (
        .req    (i_Req),
        .ptr    (ptr),
        .winner (rr_oh)
    );

    // urgent port outranks round-robin; also mux out the current owner's inputs
    always_comb begin
        pick_oh    = i_Req[URGENT_PORT] ? URG_OH : rr_oh;
        pick_idx   = '0;
        owner_req  = 1'b0;
        owner_cmd  = CMD_NOP;
        owner_addr = '0;
        owner_data = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            if (pick_oh[p]) pick_idx = PW'(p);
            if (owner == PW'(p)) begin
                owner_req  = i_Req[p];
                owner_cmd  = i_Command[2*p +: 2];
                owner_addr = i_Data_Address[ADDR_WIDTH*p +: ADDR_WIDTH];
                owner_data = i_Data_Write[DATA_WIDTH*p +: DATA_WIDTH];
            end
        end
    end

    assign busy     = (state == ST_READ_WAIT) || (state == ST_WRITE_WAIT);
    assign done     = ((state == ST_READ_WAIT) && i_Data_Read_Valid && (beat == LAST_BEAT)) ||
                      ((state == ST_WRITE_WAIT) && i_Data_Write_Done);
    assign hold_inc = (hold == HOLD_MAX) ? hold : hold + 1'b1;
    assign stay     = owner_req && (hold_inc < HOLD_MAX) &&
                      !(i_Req[URGENT_PORT] && (owner != URG_IDX));

    // state register; reset abandons any transaction in flight
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state    <= ST_IDLE;
            grant    <= '0;
            owner    <= '0;
            ptr      <= '0;
            hold     <= '0;
            beat     <= '0;
            cmd_reg  <= CMD_NOP;
            addr_reg <= '0;
            data_reg <= '0;
        end else begin
            state    <= state_n;
            grant    <= grant_n;
            owner    <= owner_n;
            ptr      <= ptr_n;
            hold     <= hold_n;
            beat     <= beat_n;
            cmd_reg  <= cmd_n;
            addr_reg <= addr_n;
            data_reg <= data_n;
        end
    end

    // next-state: grant, latch transaction, count beats, decide keep/release at boundary
    always_comb begin
        state_n = state;
        grant_n = grant;
        owner_n = owner;
        ptr_n   = ptr;
        hold_n  = hold;
        beat_n  = beat;
        cmd_n   = cmd_reg;
        addr_n  = addr_reg;
        data_n  = data_reg;
        case (state)
            ST_IDLE: begin
                if (|i_Req) begin
                    state_n = ST_OWNED;
                    grant_n = pick_oh;
                    owner_n = pick_idx;
                    ptr_n   = (pick_idx == LAST_PORT) ? '0 : pick_idx + 1'b1;
                    hold_n  = '0;
                end
            end
            ST_OWNED: begin
                if (!owner_req) begin
                    state_n = ST_IDLE;
                    grant_n = '0;
                end else if (owner_cmd == CMD_READ || owner_cmd == CMD_WRITE) begin
                    state_n = (owner_cmd == CMD_READ) ? ST_READ_WAIT : ST_WRITE_WAIT;
                    cmd_n   = owner_cmd;
                    addr_n  = owner_addr;
                    data_n  = owner_data;
                    beat_n  = '0;
                end
            end
            ST_READ_WAIT, ST_WRITE_WAIT: begin
                if (state == ST_READ_WAIT && i_Data_Read_Valid && !done)
                    beat_n = beat + 1'b1;
                if (done) begin
                    hold_n  = hold_inc;
                    beat_n  = '0;
                    cmd_n   = CMD_NOP;
                    state_n = stay ? ST_OWNED : ST_IDLE;
                    grant_n = stay ? grant : '0;
                end
            end
            default: begin
                state_n = ST_IDLE;
                grant_n = '0;
            end
        endcase
    end

    assign o_Grant           = grant;
    assign o_Busy            = busy;
    assign o_Command         = (busy && !done) ? cmd_reg : CMD_NOP;
    assign o_Data_Address    = addr_reg;
    assign o_Data_Write      = data_reg;
    assign o_Data_Read_Valid = {N_PORTS{(state == ST_READ_WAIT) && i_Data_Read_Valid && !i_Reset}} & grant;
    assign o_Data_Write_Done = {N_PORTS{(state == ST_WRITE_WAIT) && i_Data_Write_Done && !i_Reset}} & grant;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - directed self-checking bench for sdram_arbiter
module tb_sdram_arbiter;

    localparam int NP = 3;
    localparam int AW = 22;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [NP-1:0]   req;
    logic [2*NP-1:0] cmd;
    logic [AW*NP-1:0] addr;
    logic [DW*NP-1:0] wdata;
    logic [NP-1:0]   grant;
    logic [1:0]      o_cmd;
    logic [AW-1:0]   o_addr;
    logic [DW-1:0]   o_data;
    logic            rd_valid, wr_done;
    logic [NP-1:0]   o_rd_valid, o_wr_done;
    logic            busy;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sdram_arbiter dut (
        .i_Clk             (clk),
        .i_Reset           (rst),
        .i_Req             (req),
        .i_Command         (cmd),
        .i_Data_Address    (addr),
        .i_Data_Write      (wdata),
        .o_Grant           (grant),
        .o_Command         (o_cmd),
        .o_Data_Address    (o_addr),
        .o_Data_Write      (o_data),
        .i_Data_Read_Valid (rd_valid),
        .i_Data_Write_Done (wr_done),
        .o_Data_Read_Valid (o_rd_valid),
        .o_Data_Write_Done (o_wr_done),
        .o_Busy            (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant();
        for (int i = 0; i < 6; i++) begin
            if (grant != '0) break;
            step();
        end
    endtask

    task automatic wait_busy();
        for (int i = 0; i < 6; i++) begin
            if (busy) break;
            step();
        end
    endtask

    int pulses;
    int owner_seq [4] = '{0, 2, 0, 2};

    initial begin
        rst = 1'b1; req = '0; cmd = '0; addr = '0; wdata = '0;
        rd_valid = 1'b0; wr_done = 1'b0;
        step(); step();
        #1;
        check("rst_grant", 64'(grant), 64'h0);
        check("rst_cmd", 64'(o_cmd), 64'h0);
        check("rst_addr", 64'(o_addr), 64'h0);
        check("rst_data", 64'(o_data), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_strobes", 64'({o_rd_valid, o_wr_done}), 64'h0);
        step();
        rst = 1'b0;

        // stray write-done while idle
        wr_done = 1'b1;
        #1;
        check("stray_wd_out", 64'(o_wr_done), 64'h0);
        step();
        check("stray_wd_grant", 64'(grant), 64'h0);
        check("stray_wd_busy", 64'(busy), 64'h0);
        wr_done = 1'b0;

        // single port-0 read burst
        req = 3'b001; cmd[1:0] = 2'd1; addr[AW-1:0] = 22'h000100;
        step();
        check("rd_grant", 64'(grant), 64'h1);
        check("rd_owned_cmd", 64'(o_cmd), 64'h0);
        step();
        cmd[1:0] = 2'd0;
        check("rd_cmd", 64'(o_cmd), 64'h1);
        check("rd_addr", 64'(o_addr), 64'h100);
        check("rd_busy", 64'(busy), 64'h1);
        pulses = 0;
        for (int b = 0; b < 8; b++) begin
            rd_valid = 1'b1;
            #1;
            if (o_rd_valid == 3'b001) pulses++;
            check("rd_beat_cmd", 64'(o_cmd), (b == 7) ? 64'h0 : 64'h1);
            check("rd_beat_steer", 64'(o_rd_valid), 64'h1);
            step();
        end
        rd_valid = 1'b0;
        #1;
        check("rd_pulses", 64'(pulses), 64'd8);
        check("rd_after_busy", 64'(busy), 64'h0);
        check("rd_after_grant", 64'(grant), 64'h1);
        check("rd_after_cmd", 64'(o_cmd), 64'h0);

        // command value 3 is a no-op and keeps the grant
        cmd[1:0] = 2'd3;
        step(); step();
        check("cmd3_busy", 64'(busy), 64'h0);
        check("cmd3_grant", 64'(grant), 64'h1);
        check("cmd3_cmd", 64'(o_cmd), 64'h0);

        // urgent request mid-burst waits for the burst to finish
        cmd[1:0] = 2'd1;
        step();
        cmd[1:0] = 2'd0;
        check("urg_busy", 64'(busy), 64'h1);
        for (int b = 0; b < 8; b++) begin
            rd_valid = 1'b1;
            if (b == 4) req = 3'b011;
            #1;
            check("urg_burst_grant", 64'(grant), 64'h1);
            check("urg_burst_steer", 64'(o_rd_valid), 64'h1);
            step();
        end
        rd_valid = 1'b0;
        #1;
        check("urg_release", 64'(grant), 64'h0);
        step();
        check("urg_granted", 64'(grant), 64'h2);
        req = 3'b000;
        step();
        check("urg_drop", 64'(grant), 64'h0);

        // reset at beat 4 of a read
        req = 3'b001; cmd[1:0] = 2'd1; addr[AW-1:0] = 22'h00002A;
        step();
        check("rr_grant", 64'(grant), 64'h1);
        step();
        cmd[1:0] = 2'd0;
        check("rr_busy", 64'(busy), 64'h1);
        for (int b = 0; b < 3; b++) begin
            rd_valid = 1'b1;
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0; req = 3'b000;
        #1;
        check("rr_after_grant", 64'(grant), 64'h0);
        check("rr_after_cmd", 64'(o_cmd), 64'h0);
        check("rr_after_busy", 64'(busy), 64'h0);
        for (int b = 0; b < 4; b++) begin
            #1;
            check("rr_ignored_beat", 64'(o_rd_valid), 64'h0);
            step();
        end
        rd_valid = 1'b0;

        // fresh request from port 2 after reset
        req = 3'b100; cmd[5:4] = 2'd2;
        addr[3*AW-1:2*AW] = 22'h3FFFFF; wdata[3*DW-1:2*DW] = 32'hDEADBEEF;
        step();
        check("wr_grant", 64'(grant), 64'h4);
        step();
        cmd[5:4] = 2'd0;
        check("wr_cmd", 64'(o_cmd), 64'h2);
        check("wr_addr", 64'(o_addr), 64'h3FFFFF);
        check("wr_data", 64'(o_data), 64'hDEADBEEF);
        step();
        check("wr_hold_cmd", 64'(o_cmd), 64'h2);
        wr_done = 1'b1;
        #1;
        check("wr_done_steer", 64'(o_wr_done), 64'h4);
        check("wr_done_cmd", 64'(o_cmd), 64'h0);
        step();
        wr_done = 1'b0; req = 3'b000;
        #1;
        check("wr_after_busy", 64'(busy), 64'h0);
        check("wr_after_grant", 64'(grant), 64'h4);
        step();
        check("wr_drop", 64'(grant), 64'h0);

        // ports 0 and 2 stream writes; hand-over every 16 transactions
        cmd[1:0] = 2'd2; cmd[5:4] = 2'd2; req = 3'b101;
        for (int g = 0; g < 4; g++) begin
            wait_grant();
            check("hold_owner", 64'(grant), 64'(3'b001 << owner_seq[g]));
            for (int t = 0; t < 16; t++) begin
                wait_busy();
                check("hold_busy", 64'(busy), 64'h1);
                wr_done = 1'b1;
                #1;
                check("hold_steer", 64'(o_wr_done), 64'(3'b001 << owner_seq[g]));
                step();
                wr_done = 1'b0;
            end
            #1;
            check("hold_release", 64'(grant), 64'h0);
        end
        req = 3'b000;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
